// File: rtl/axi_master_port.sv
// axi_master_port
//   Bridges a simple CPU-side request/response port onto an AXI master.
//   Only one transaction is in flight at a time. Reads may be bursts of
//   req_len+1 beats. Writes are always a single beat.
//
// Ports
//   ACLK, ARESET           clock and synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write, req_addr, req_wdata, req_wstrb, req_len   request fields
//   rsp_valid/rsp_rdata/rsp_last/rsp_err                  response beat
//   AW/W/B/AR/R            AXI master channels (ID 4, ADDR 32, DATA 32)
module axi_master_port #(
  parameter logic [3:0] MASTER_ID  = 4'h0,
  parameter logic [1:0] BURST_TYPE = 2'b01
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // CPU side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [3:0]  req_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        rsp_err,
  // AW
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // W
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // B
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // AR
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  // R
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WADDR, WDATA_S, WRESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic        req_fire;
  logic        len_hit;

  assign req_fire = (state_q == IDLE) && req_valid;
  assign len_hit  = (beat_q == len_q);

  // Channel payloads come straight from the capture registers. Those
  // registers only load in IDLE, so every field stays stable while its VALID
  // is high.
  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = 3'b010;
  assign ARBURST = BURST_TYPE;
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = BURST_TYPE;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = req_write ? WADDR : RADDR;
      RADDR:   if (ARREADY) state_d = RDATA_S;
      RDATA_S: if (RVALID && RLAST) state_d = IDLE;
      WADDR:   if (AWREADY) state_d = WDATA_S;
      WDATA_S: if (WREADY) state_d = WRESP;
      WRESP:   if (BVALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and read beat counter
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else if (req_fire) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
      len_q   <= req_write ? 4'd0 : req_len;
      beat_q  <= '0;
    end else if (state_q == RDATA_S && RVALID) begin
      beat_q  <= beat_q + 4'd1;
    end
  end

  // Output logic. The response READYs and rsp_valid are masked during reset.
  // A beat arriving in the reset cycle is therefore neither accepted nor
  // reported.
  always_comb begin
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    RREADY    = 1'b0;
    BREADY    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RADDR:   ARVALID   = 1'b1;
      WADDR:   AWVALID   = 1'b1;
      WDATA_S: WVALID    = 1'b1;
      RDATA_S: begin
        RREADY    = !ARESET;
        rsp_valid = RVALID && !ARESET;
        rsp_rdata = RDATA;
        // Reaching the requested beat count terminates the response even if
        // the slave has not raised RLAST. A missing RLAST is flagged as an error.
        rsp_last  = RVALID && (RLAST || len_hit);
        rsp_err   = RVALID && ((RRESP != 2'b00) || (RID != MASTER_ID) ||
                               (len_hit && !RLAST));
      end
      WRESP: begin
        BREADY    = !ARESET;
        rsp_valid = BVALID && !ARESET;
        rsp_last  = BVALID;
        rsp_err   = BVALID && ((BRESP != 2'b00) || (BID != MASTER_ID));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_port.sv
// tb_axi_master_port
//   Drives CPU requests and acts as the AXI slave. Delays, data and responses
//   are chosen per transaction. The expected value of every response beat and
//   channel field is worked out from the request and from what the slave returned.
module tb_axi_master_port;
  localparam logic [3:0] MID = 4'h5;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb, req_len;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWID, AWLEN, WSTRB, BID, ARID, ARLEN, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 ACLK = ~ACLK;

  axi_master_port #(.MASTER_ID(MID), .BURST_TYPE(2'b01)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_arvalid"}, 32'(ARVALID), 0);
    chk({tag, "_awvalid"}, 32'(AWVALID), 0);
    chk({tag, "_wvalid"},  32'(WVALID), 0);
    chk({tag, "_rready"},  32'(RREADY), 0);
    chk({tag, "_bready"},  32'(BREADY), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
  endtask

  // Present a request and complete its handshake. Returns at the falling edge
  // after the accepting edge, with req_valid dropped.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [3:0] l);
    int n;
    @(negedge ACLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    req_wstrb = s; req_len = l;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge ACLK); @(negedge ACLK); #1; n++;
    end
    chk("req_ready", 32'(req_ready), 1);
    @(posedge ACLK); @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  // Serve a read that has already been handshaked. With late=1 the slave sends
  // len+2 beats and raises RLAST only on the final one. With abort_at>=0 a
  // reset is applied in place of that beat.
  task automatic serve_read(input logic [31:0] addr, input logic [3:0] len,
                            input int ar_dly, input int gap, input bit late,
                            input logic [3:0] rid, input logic [1:0] resp,
                            input logic [31:0] seed, input int abort_at);
    int nb;
    bit exp_last, exp_err;
    for (int c = 0; c <= ar_dly; c++) begin
      ARREADY = (c == ar_dly);
      #1;
      chk("arvalid", 32'(ARVALID), 1);
      chk("araddr", ARADDR, addr);
      chk("arlen", 32'(ARLEN), 32'(len));
      chk("arid", 32'(ARID), 32'(MID));
      chk("arsize", 32'(ARSIZE), 2);
      chk("arburst", 32'(ARBURST), 1);
      chk("req_ready_busy", 32'(req_ready), 0);
      chk("rready_raddr", 32'(RREADY), 0);
      @(posedge ACLK); @(negedge ACLK);
    end
    ARREADY = 1'b0;
    nb = late ? int'(len) + 2 : int'(len) + 1;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) begin
        ARESET = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk_all_idle("abort");
        return;
      end
      for (int g = 0; b > 0 && g < gap; g++) begin
        RVALID = 1'b0;
        #1;
        chk("rready_gap", 32'(RREADY), 1);
        chk("rsp_valid_gap", 32'(rsp_valid), 0);
        @(posedge ACLK); @(negedge ACLK);
      end
      RVALID = 1'b1;
      RDATA  = seed ^ (32'(b) * 32'h9E37_79B9);
      RLAST  = (b == nb - 1);
      RID    = rid;
      RRESP  = resp;
      exp_last = (b == int'(len)) || (b == nb - 1);
      exp_err  = (resp != 2'b00) || (rid != MID) || (late && b == int'(len));
      #1;
      chk("rready", 32'(RREADY), 1);
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_rdata", rsp_rdata, RDATA);
      chk("rsp_last", 32'(rsp_last), 32'(exp_last));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("req_ready_rdata", 32'(req_ready), 0);
      @(posedge ACLK); @(negedge ACLK);
      RVALID = 1'b0; RLAST = 1'b0;
    end
    #1;
    chk("req_ready_done", 32'(req_ready), 1);
    chk("rready_done", 32'(RREADY), 0);
    n_txn++;
    $display("txn %0d READ addr=%h len=%0d ar_dly=%0d gap=%0d late=%0d rid=%h resp=%0d",
             n_txn, addr, len, ar_dly, gap, late, rid, resp);
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [3:0] bid,
                             input logic [1:0] bresp);
    for (int c = 0; c <= aw_dly; c++) begin
      AWREADY = (c == aw_dly);
      #1;
      chk("awvalid", 32'(AWVALID), 1);
      chk("wvalid_early", 32'(WVALID), 0);
      chk("awaddr", AWADDR, addr);
      chk("awlen", 32'(AWLEN), 0);
      chk("awsize", 32'(AWSIZE), 2);
      chk("awburst", 32'(AWBURST), 1);
      chk("awid", 32'(AWID), 32'(MID));
      @(posedge ACLK); @(negedge ACLK);
    end
    AWREADY = 1'b0;
    for (int c = 0; c <= w_dly; c++) begin
      WREADY = (c == w_dly);
      #1;
      chk("wvalid", 32'(WVALID), 1);
      chk("awvalid_w", 32'(AWVALID), 0);
      chk("wdata", WDATA, d);
      chk("wstrb", 32'(WSTRB), 32'(s));
      chk("wlast", 32'(WLAST), 1);
      @(posedge ACLK); @(negedge ACLK);
    end
    WREADY = 1'b0;
    for (int c = 0; c <= b_dly; c++) begin
      BVALID = (c == b_dly);
      BID = bid; BRESP = bresp;
      #1;
      chk("bready", 32'(BREADY), 1);
      chk("wvalid_b", 32'(WVALID), 0);
      chk("rsp_valid_b", 32'(rsp_valid), 32'(c == b_dly));
      if (c == b_dly) begin
        chk("rsp_last_b", 32'(rsp_last), 1);
        chk("rsp_err_b", 32'(rsp_err), 32'((bresp != 2'b00) || (bid != MID)));
      end
      @(posedge ACLK); @(negedge ACLK);
    end
    BVALID = 1'b0;
    #1;
    chk("req_ready_wdone", 32'(req_ready), 1);
    n_txn++;
    $display("txn %0d WRITE addr=%h data=%h strb=%b bid=%h bresp=%0d",
             n_txn, addr, d, s, bid, bresp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  l, s, id;
    logic [1:0]  rs;
    ARESET = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_len = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_all_idle("reset");
    ARESET = 1'b0;

    // Single read with immediate readys
    issue(1'b0, 32'h0000_1004, 32'h0, 4'h0, 4'd0);
    serve_read(32'h0000_1004, 4'd0, 0, 0, 1'b0, MID, 2'b00, 32'hDEAD_BEEF, -1);
    // Burst of 4 beats, ARREADY delayed 3 cycles, 2 idle cycles between beats
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0, 4'd3);
    serve_read(32'h0000_3000, 4'd3, 3, 2, 1'b0, MID, 2'b00, 32'h1111_0000, -1);
    // Write with AWREADY delayed 2 cycles
    issue(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 4'd9);
    serve_write(32'h0000_2000, 32'h1234_5678, 4'b0011, 2, 0, 1, MID, 2'b00);
    // Write with SLVERR, then a normal read
    issue(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 4'd0);
    serve_write(32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 0, 1, 0, MID, 2'b10);
    issue(1'b0, 32'h0000_2004, 32'h0, 4'h0, 4'd1);
    serve_read(32'h0000_2004, 4'd1, 0, 0, 1'b0, MID, 2'b00, 32'h0BAD_F00D, -1);
    // Reset during a len-3 burst after the first beat, then stray RVALID
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, 4'd3);
    serve_read(32'h0000_4000, 4'd3, 0, 0, 1'b0, MID, 2'b00, 32'h5555_0000, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge ACLK);
      RVALID = 1'b1; RLAST = 1'b1;
      #1;
      chk("stray_rsp_valid", 32'(rsp_valid), 0);
      chk("stray_rready", 32'(RREADY), 0);
    end
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
    $display("txn - RESET abort checked");
    // Slave omits RLAST on the expected last beat
    issue(1'b0, 32'h0000_5000, 32'h0, 4'h0, 4'd2);
    serve_read(32'h0000_5000, 4'd2, 1, 1, 1'b1, MID, 2'b00, 32'h7777_0000, -1);
    // Response with a foreign ID
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0, 4'd0);
    serve_read(32'h0000_6000, 4'd0, 0, 0, 1'b0, 4'hA, 2'b00, 32'h6666_6666, -1);
    // req_valid held high: the second request's fields must not be captured early
    issue(1'b0, 32'h0000_7000, 32'h0, 4'h0, 4'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_8000; req_len = 4'd2;
    serve_read(32'h0000_7000, 4'd1, 1, 1, 1'b0, MID, 2'b00, 32'hAAAA_0000, -1);
    @(posedge ACLK); @(negedge ACLK);
    req_valid = 1'b0;
    serve_read(32'h0000_8000, 4'd2, 0, 0, 1'b0, MID, 2'b00, 32'hBBBB_0000, -1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      d  = $urandom;
      s  = 4'($urandom);
      l  = 4'($urandom_range(0, 7));
      id = ($urandom_range(0, 5) == 0) ? 4'($urandom) : MID;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        issue(1'b1, a, d, s, l);
        serve_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), id, rs);
      end else begin
        issue(1'b0, a, d, s, l);
        serve_read(a, l, $urandom_range(0, 3), $urandom_range(0, 2),
                   ($urandom_range(0, 4) == 0), id, rs, $urandom, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_master_port.md
AXI_MASTER_PORT -- requirements
Module: axi_master_port

Interface
REQ-001 Parameter MASTER_ID, default 4'h0, AXI ID driven on ARID/AWID.
REQ-002 Parameter BURST_TYPE, default 2'b01 (INCR), driven on ARBURST/AWBURST.
REQ-003 ACLK  input  1  sole clock; all state updates on rising edge.
REQ-004 ARESET  input  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  input/output  1/1  CPU-side request handshake; transfer when both high.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr/req_wdata  input  32/32  byte address / write data.
REQ-008 req_wstrb  input  4  byte enables, active-high.
REQ-009 req_len  input  4  read beats minus 1; ignored for writes, which are single-beat.
REQ-010 rsp_valid/rsp_rdata/rsp_last  output  1/32/1  one pulse per read beat / write completion; rdata is don't-care on writes.
REQ-011 rsp_err  output  1  valid with rsp_valid; 1 when RRESP/BRESP != 2'b00.
REQ-012 AXI master channels AW/W/B/AR/R, with widths ID 4, ADDR 32, DATA 32, LEN 4, SIZE 3, STRB 4, RESP 2, and all *VALID/*READY/WLAST/RLAST 1 bit.

Function
REQ-013 FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
REQ-014 req_ready SHALL be 1 only in IDLE; the request is captured into internal registers on handshake.
REQ-015 IDLE->RADDR on a read handshake; IDLE->WADDR on a write handshake; otherwise remain in IDLE.
REQ-016 RADDR: ARVALID=1 with registered ARID/ARADDR/ARLEN, ARSIZE=3'b010; move to RDATA on ARREADY.
REQ-017 ARVALID and all AR fields SHALL stay stable until ARREADY; the same rule applies to AW and W.
REQ-018 RDATA: RREADY=1; each RVALID beat produces rsp_valid=1 the same cycle, with rsp_rdata=RDATA and rsp_last=RLAST; a 4-bit beat counter increments per beat.
REQ-019 RDATA->IDLE on a beat with RLAST=1.
REQ-020 If the beat counter equals the captured len while RLAST=0, rsp_last SHALL still be 1 and rsp_err=1; the state remains in RDATA until RLAST arrives.
REQ-021 WADDR: AWVALID=1, AWLEN=0, AWSIZE=3'b010; move to WDATA on AWREADY.
REQ-022 WADDR: W SHALL NOT be asserted before the AW handshake.
REQ-023 WDATA: WVALID=1, WLAST=1, with registered WDATA/WSTRB; move to WRESP on WREADY.
REQ-024 WRESP: BREADY=1; on BVALID, rsp_valid=1, rsp_last=1, rsp_err=(BRESP!=0); return to IDLE.
REQ-025 Responses whose ID differs from MASTER_ID SHALL still be accepted, with rsp_err=1.
REQ-026 Exactly one transaction SHALL be outstanding; a new request is accepted no earlier than the cycle after returning to IDLE, with no same-cycle back-to-back acceptance.
REQ-027 Minimum latency for a single read with immediate READYs: request handshake at cycle 0, ARVALID at cycle 1, rsp_valid at cycle 2 at the earliest.
REQ-028 RREADY/BREADY SHALL be 0 outside RDATA/WRESP; stray RVALID/BVALID outside those states are ignored.

Reset
REQ-029 While ARESET=1 at a clock edge: state=IDLE; ARVALID/AWVALID/WVALID/RREADY/BREADY/rsp_valid/rsp_last/rsp_err=0; req_ready=1 the following cycle; beat counter and captured registers=0.
REQ-030 Reset mid-transaction SHALL abandon the transfer with no response generated; all VALIDs drop at the next edge.

Verification
REQ-031 Single read, addr 0x0000_1004, len 0, slave ARREADY/RVALID immediate, RDATA 0xDEADBEEF -> one rsp_valid with rdata 0xDEADBEEF, rsp_last=1, rsp_err=0.
REQ-032 Burst read, len 3, slave inserts 2 RVALID-low cycles between beats -> 4 rsp_valid pulses in order, rsp_last only on the 4th, and ARADDR held stable while ARREADY is delayed 3 cycles.
REQ-033 Write, addr 0x0000_2000, wdata 0x12345678, wstrb 4'b0011, AWREADY delayed 2 cycles -> WVALID is not seen before the AW handshake; WSTRB=0011, WLAST=1; one rsp_valid after BVALID.
REQ-034 Write with BRESP=2'b10 -> rsp_valid=1, rsp_err=1; the next read request is accepted normally.
REQ-035 ARESET asserted while in RDATA after beat 1 of a len-3 burst -> next cycle all VALID/READY outputs are 0, req_ready=1, and no rsp_valid is produced.
REQ-036 req_valid held high during a read -> req_ready=0 until IDLE, and the second request's fields are captured only once req_ready=1.
